// File: rtl/bclk_mon_pkg.sv
// bclk_mon_pkg: shared states, default parameters and range helper for the bit-clock monitor.
package bclk_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_e;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_PERIOD_MIN     = 90;
  localparam int DEF_PERIOD_MAX     = 110;
  localparam int DEF_LOCK_COUNT     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;
  function automatic logic in_range(input int unsigned p, input int unsigned lo, input int unsigned hi);
    return (p >= lo) && (p <= hi);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with registered rise/fall pulses.
module sync_edge_detect import bclk_mon_pkg::*; #(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic dly_q, rise_q, fall_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[STAGES-1] & dly_q;
    end
  end
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/bclk_tick_monitor.sv
// bclk_tick_monitor: bit-clock tick generation, period measurement, lock tracking and stall watchdog.
module bclk_tick_monitor import bclk_mon_pkg::*; #(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int PERIOD_MIN     = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX     = DEF_PERIOD_MAX,
  parameter int LOCK_COUNT     = DEF_LOCK_COUNT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bclk_i,
  input  logic             enable_i,
  input  logic             clr_timeout_i,
  output logic             tick_rise_o,
  output logic             tick_fall_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             timeout_o
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] WD_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wd_q, wd_d, period_q, period_d, p;
  logic [GW-1:0] good_q, good_d;
  logic pv_q, pv_d, timeout_q, timeout_d, rise, fall, wd_hit, ok;
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bclk_i),
    .level_o(),
    .rise_o (rise),
    .fall_o (fall)
  );
  always_comb begin
    p         = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
    ok        = in_range(32'(p), PERIOD_MIN, PERIOD_MAX);
    // an edge in the terminal-count cycle suppresses the timeout
    wd_hit    = enable_i && (state_q != IDLE) && !(rise || fall) && (wd_q == WD_TERM);
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    cnt_d     = rise ? '0 : p;
    wd_d      = (rise || fall || wd_hit) ? '0 : wd_q + 1'b1;
    timeout_d = wd_hit | (timeout_q & ~clr_timeout_i);
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      wd_d    = '0;
      good_d  = '0;
    end else if (wd_hit) begin
      state_d = ACQUIRE;
      good_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
    end else if (rise && state_q == ACQUIRE) begin
      state_d = TRACK;
    end else if (rise) begin
      period_d = p;
      pv_d     = 1'b1;
      if (!ok) begin
        good_d  = '0;
        state_d = TRACK;
      end else if (state_q == TRACK) begin
        good_d  = good_q + 1'b1;
        state_d = (good_q + 1'b1 == GW'(LOCK_COUNT)) ? LOCKED : TRACK;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      period_q  <= '0;
      good_q    <= '0;
      pv_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      period_q  <= period_d;
      good_q    <= good_d;
      pv_q      <= pv_d;
      timeout_q <= timeout_d;
    end
  end
  assign tick_rise_o    = rise;
  assign tick_fall_o    = fall;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign locked_o       = (state_q == LOCKED);
  assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_bclk_tick_monitor.sv
// tb_bclk_tick_monitor: scoreboard bench for bclk_tick_monitor plus a narrow-counter instance for saturation.
module tb_bclk_tick_monitor;
  typedef struct {logic [15:0] p; logic l;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, en = 1'b0, clr = 1'b0;
  logic bclk2 = 1'b0, en2 = 1'b0;
  logic tick_rise, tick_fall, pv, locked, timeout;
  logic [15:0] period;
  logic tick_rise2, tick_fall2, pv2, locked2, timeout2;
  logic [7:0] period2;
  int checks = 0, errors = 0;
  int prev_len = 0, m_good = 0;
  logic m_locked = 1'b0;
  int sat_pv = 0;
  logic [7:0] sat_period = '0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bclk_tick_monitor u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bclk_i(bclk), .enable_i(en), .clr_timeout_i(clr),
    .tick_rise_o(tick_rise), .tick_fall_o(tick_fall), .period_o(period),
    .period_valid_o(pv), .locked_o(locked), .timeout_o(timeout)
  );

  bclk_tick_monitor #(.CNT_W(8), .TIMEOUT_CYCLES(200)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .bclk_i(bclk2), .enable_i(en2), .clr_timeout_i(1'b0),
    .tick_rise_o(tick_rise2), .tick_fall_o(tick_fall2), .period_o(period2),
    .period_valid_o(pv2), .locked_o(locked2), .timeout_o(timeout2)
  );

  always @(negedge clk) begin
    if (pv) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pv: period=%0d locked=%0b, no period expected", period, locked);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (period !== e.p || locked !== e.l) begin
          errors++;
          $display("FAIL period_check: got period=%0d locked=%0b, want period=%0d locked=%0b", period, locked, e.p, e.l);
        end
      end
    end
    if (pv2) begin
      sat_pv++;
      sat_period = period2;
    end
  end

  task automatic push(input int len);
    int p;
    exp_t e;
    p = (len > 65535) ? 65535 : len;
    if (p < 90 || p > 110) begin
      m_good = 0;
      m_locked = 1'b0;
    end else if (!m_locked) begin
      m_good++;
      if (m_good == 4) m_locked = 1'b1;
    end
    e.p = 16'(p);
    e.l = m_locked;
    exp_q.push_back(e);
  endtask

  task automatic bclk_cycle(input int hi, input int lo);
    bclk = 1'b1;
    if (prev_len > 0) push(prev_len);
    repeat (hi) @(negedge clk);
    bclk = 1'b0;
    repeat (lo) @(negedge clk);
    prev_len = hi + lo;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tick_rise, tick_fall, pv, locked, timeout, period} !== '0) begin
      errors++;
      $display("FAIL reset_main: outputs=%0h, want 0", {tick_rise, tick_fall, pv, locked, timeout, period});
    end
    checks++;
    if ({tick_rise2, tick_fall2, pv2, locked2, timeout2, period2} !== '0) begin
      errors++;
      $display("FAIL reset_sat: outputs=%0h, want 0", {tick_rise2, tick_fall2, pv2, locked2, timeout2, period2});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lock;
    int n;
    en = 1'b1;
    prev_len = 0;
    fork
      repeat (5) bclk_cycle(50, 50);
      begin
        n = 0;
        while (tick_rise !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (tick_rise !== 1'b1) begin errors++; $display("FAIL first_tick: tick_rise=%0b after %0d cycles, want 1", tick_rise, n); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick_fall !== 1'b1 && n < 200);
        checks++;
        if (n != 50) begin errors++; $display("FAIL rise_to_fall: %0d cycles, want 50", n); end
        n = 0;
        do begin @(negedge clk); n++; end while (tick_rise !== 1'b1 && n < 200);
        checks++;
        if (n != 50) begin errors++; $display("FAIL fall_to_rise: %0d cycles, want 50", n); end
      end
    join
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock: locked=%0b, want 1", locked); end
  endtask

  task automatic test_unlock;
    bclk_cycle(60, 60);
    repeat (5) bclk_cycle(50, 50);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: locked=%0b, want 1", locked); end
  endtask

  task automatic test_timeout;
    int n, k;
    bclk = 1'b1;
    push(prev_len);
    n = 0;
    while (tick_rise !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    k = 0;
    do begin @(negedge clk); k++; end while (timeout !== 1'b1 && k < 400);
    checks++;
    if (k != 257) begin errors++; $display("FAIL timeout_latency: %0d cycles, want 257", k); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL timeout_unlock: locked=%0b, want 0", locked); end
    m_locked = 1'b0;
    m_good = 0;
    prev_len = 0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: timeout=%0b, want 0", timeout); end
    k = 2;
    do begin @(negedge clk); k++; end while (timeout !== 1'b1 && k < 400);
    checks++;
    if (k != 256) begin errors++; $display("FAIL timeout_repeat: %0d cycles, want 256", k); end
  endtask

  task automatic test_coincide;
    int n;
    @(negedge clk);
    clr = 1'b1;
    bclk = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (tick_fall !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (tick_fall !== 1'b1) begin errors++; $display("FAIL coincide_fall: tick_fall=%0b, want 1", tick_fall); end
    repeat (253) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tick_rise !== 1'b1) begin errors++; $display("FAIL terminal_edge: tick_rise=%0b, want 1", tick_rise); end
    repeat (2) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL edge_wins: timeout=%0b, want 0", timeout); end
    repeat (254) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL pre_terminal: timeout=%0b, want 0", timeout); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL set_wins: timeout=%0b, want 1", timeout); end
    prev_len = 0;
  endtask

  task automatic test_saturate;
    en2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bclk2 = 1'b1;
      repeat (150) @(negedge clk);
      bclk2 = 1'b0;
      repeat (150) @(negedge clk);
    end
    checks++;
    if (sat_pv != 2) begin errors++; $display("FAIL sat_pv_count: %0d, want 2", sat_pv); end
    checks++;
    if (sat_period !== 8'hFF) begin errors++; $display("FAIL sat_period: %0d, want 255", sat_period); end
    checks++;
    if (locked2 !== 1'b0 || timeout2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_flags: locked=%0b timeout=%0b, want 0 0", locked2, timeout2);
    end
    en2 = 1'b0;
  endtask

  task automatic test_reset_mid;
    bclk = 1'b0;
    repeat (5) @(negedge clk);
    prev_len = 0;
    repeat (5) bclk_cycle(50, 50);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_lock: locked=%0b, want 1", locked); end
    bclk = 1'b1;
    push(prev_len);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tick_rise, tick_fall, pv, locked, timeout, period} !== '0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%0h, want 0", {tick_rise, tick_fall, pv, locked, timeout, period});
    end
    rst_n = 1'b1;
    bclk = 1'b0;
    m_locked = 1'b0;
    m_good = 0;
    prev_len = 0;
  endtask

  task automatic test_disable;
    int n;
    n = 0;
    while (timeout !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL stall_timeout: timeout=%0b, want 1", timeout); end
    repeat (5) bclk_cycle(50, 50);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_before_disable: locked=%0b, want 1", locked); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (locked !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL disable: locked=%0b timeout=%0b, want 0 1", locked, timeout);
    end
    bclk = 1'b1;
    n = 0;
    while (tick_rise !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (tick_rise !== 1'b1) begin errors++; $display("FAIL idle_tick: tick_rise=%0b, want 1", tick_rise); end
    repeat (10) @(negedge clk);
    checks++;
    if (period !== 16'd100) begin errors++; $display("FAIL period_hold: %0d, want 100", period); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_unlock;
    test_timeout;
    test_coincide;
    test_saturate;
    test_reset_mid;
    test_disable;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
